// File: rtl/simplex_ica_if.sv
// rtl/simplex_ica_if.sv - sample load / result bundle for the ICA block
interface simplex_ica_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 5,
    parameter int SAMPLES    = 1024
) ();
    logic signed [DATA_WIDTH-1:0]             serial_z_in;
    logic                                     serial_z_valid;
    logic                                     load_data;
    logic                                     sica_start;
    logic                                     sica_complete;
    logic        [DATA_WIDTH*DIM*SAMPLES-1:0] s_est;

    modport master (
        output serial_z_in, serial_z_valid, load_data, sica_start,
        input  sica_complete, s_est
    );

    modport slave (
        input  serial_z_in, serial_z_valid, load_data, sica_start,
        output sica_complete, s_est
    );
endinterface

// File: rtl/simplex_ica_top.sv
// rtl/simplex_ica_top.sv - pairwise Givens-rotation source separation over a serially loaded window
module simplex_ica_top #(
    parameter int DATA_WIDTH     = 32,
    parameter int SAMPLES        = 1024,
    parameter int DIM            = 5,
    parameter int MAX_ITERATIONS = 500,
    parameter int CORDIC_STAGES  = 16,
    parameter int CORDIC_WIDTH   = 38,
    parameter int FRAC_WIDTH     = 20,
    parameter int LOGM           = 10,
    parameter int ANGLE_WIDTH    = 16
) (
    input  logic         clk,
    input  logic         nreset,
    simplex_ica_if.slave bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int CW    = CORDIC_WIDTH;
    localparam int F     = FRAC_WIDTH;
    localparam int PWW   = 2 * CW;
    localparam int CAW   = CW + LOGM;
    localparam int TOTAL = DIM * SAMPLES;
    localparam int AW    = $clog2(TOTAL + 1);
    localparam int IW    = $clog2(TOTAL);
    localparam int PW    = $clog2(DIM);
    localparam int NW    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int KW    = (MAX_ITERATIONS > 1) ? $clog2(MAX_ITERATIONS + 1) : 1;
    localparam int SW    = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;

    localparam logic signed [PWW-1:0] SAT_MAX = {{(PWW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PWW-1:0] SAT_MIN = {{(PWW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {S_LOAD, S_MOMENT, S_ROTATE, S_NEXT, S_DONE} state_t;

    state_t state, state_nx;

    logic signed [DW-1:0]          mem [TOTAL];
    logic        [AW-1:0]          wr_ptr;
    logic        [PW-1:0]          p_idx, q_idx;
    logic        [NW-1:0]          n_idx;
    logic        [KW-1:0]          sweep;
    logic        [ANGLE_WIDTH-1:0] shift;
    logic signed [CAW-1:0]         c_acc;
    logic                          sigma_neg;
    logic                          rotated_any;

    logic                          load_wr, full, last_n, last_pair, last_sweep;
    logic        [IW-1:0]          addr_a, addr_b;
    logic signed [CW-1:0]          a_c, b_c, a2, a3, b2, b3;
    logic signed [CW-1:0]          d_a, d_b, x_pre, y_pre, kinv;
    logic signed [CAW-1:0]         c_sum;
    logic signed [DW-1:0]          x_rot, y_rot;
    logic signed [CW-1:0]          kinv_tab [CORDIC_STAGES];

    // Gain compensation of one micro-rotation, evaluated at elaboration only
    function automatic logic signed [CW-1:0] kinv_calc(input int i);
        real k;
        k = (2.0 ** F) / $sqrt(1.0 + 2.0 ** (-2.0 * i));
        return CW'($rtoi(k + 0.5));
    endfunction

    // Fixed-point multiply: full-width product, then drop the fractional bits
    function automatic logic signed [PWW-1:0] mul_shr(input logic signed [CW-1:0] x,
                                                      input logic signed [CW-1:0] y);
        logic signed [PWW-1:0] xe, ye;
        xe = PWW'(x);
        ye = PWW'(y);
        return (xe * ye) >>> F;
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [PWW-1:0] v);
        if (v > SAT_MAX)      return {1'b0, {(DW-1){1'b1}}};
        else if (v < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
        else                  return DW'(v);
    endfunction

    for (genvar g = 0; g < CORDIC_STAGES; g++) begin : g_kinv
        localparam logic signed [CW-1:0] KV = kinv_calc(g);
        assign kinv_tab[g] = KV;
    end

    for (genvar g = 0; g < TOTAL; g++) begin : g_out
        assign bus.s_est[g*DW +: DW] = mem[g];
    end

    // Sample fetch, fourth-moment gradient term and rotated pair for the current sample
    always_comb begin
        load_wr    = bus.load_data && bus.serial_z_valid;
        full       = (wr_ptr == AW'(TOTAL));
        last_n     = (n_idx == NW'(SAMPLES - 1));
        last_pair  = (p_idx == PW'(DIM - 2)) && (q_idx == PW'(DIM - 1));
        last_sweep = (sweep == KW'(MAX_ITERATIONS - 1));
        addr_a     = IW'(p_idx) * IW'(SAMPLES) + IW'(n_idx);
        addr_b     = IW'(q_idx) * IW'(SAMPLES) + IW'(n_idx);
        a_c        = {{(CW-DW){mem[addr_a][DW-1]}}, mem[addr_a]};
        b_c        = {{(CW-DW){mem[addr_b][DW-1]}}, mem[addr_b]};
        a2         = CW'(mul_shr(a_c, a_c));
        a3         = CW'(mul_shr(a2, a_c));
        b2         = CW'(mul_shr(b_c, b_c));
        b3         = CW'(mul_shr(b2, b_c));
        c_sum      = c_acc + CAW'(mul_shr(a3, b_c)) - CAW'(mul_shr(a_c, b3));
        kinv       = kinv_tab[shift[SW-1:0]];
        d_a        = a_c >>> shift;
        d_b        = b_c >>> shift;
        x_pre      = sigma_neg ? (a_c + d_b) : (a_c - d_b);
        y_pre      = sigma_neg ? (b_c - d_a) : (b_c + d_a);
        x_rot      = sat_dw(mul_shr(x_pre, kinv));
        y_rot      = sat_dw(mul_shr(y_pre, kinv));
    end

    // State register
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) state <= S_LOAD;
        else        state <= state_nx;
    end

    // Next-state: an explicit start with a full buffer behaves like the auto-start
    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:   if (full || (bus.sica_start && full)) state_nx = S_MOMENT;
            S_MOMENT: if (last_n) state_nx = (c_sum != '0) ? S_ROTATE : S_NEXT;
            S_ROTATE: if (last_n) state_nx = S_NEXT;
            S_NEXT:   state_nx = (last_pair && (!rotated_any || last_sweep)) ? S_DONE : S_MOMENT;
            S_DONE:   if (load_wr) state_nx = S_LOAD;
            default:  state_nx = S_LOAD;
        endcase
    end

    // Completion flag is a plain decode of the finished state
    always_comb begin
        bus.sica_complete = (state == S_DONE);
    end

    // Window buffer, pair/sample/sweep counters and moment accumulator
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            for (int i = 0; i < TOTAL; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            n_idx       <= '0;
            p_idx       <= '0;
            q_idx       <= PW'(1);
            sweep       <= '0;
            shift       <= '0;
            c_acc       <= '0;
            sigma_neg   <= 1'b0;
            rotated_any <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (full) begin
                        n_idx       <= '0;
                        p_idx       <= '0;
                        q_idx       <= PW'(1);
                        sweep       <= '0;
                        shift       <= '0;
                        c_acc       <= '0;
                        rotated_any <= 1'b0;
                    end else if (load_wr) begin
                        mem[wr_ptr[IW-1:0]] <= bus.serial_z_in;
                        wr_ptr              <= wr_ptr + AW'(1);
                    end
                end
                S_MOMENT: begin
                    c_acc <= c_sum;
                    n_idx <= last_n ? '0 : n_idx + NW'(1);
                    if (last_n) begin
                        sigma_neg <= c_sum[CAW-1];
                        if (c_sum != '0) rotated_any <= 1'b1;
                    end
                end
                S_ROTATE: begin
                    mem[addr_a] <= x_rot;
                    mem[addr_b] <= y_rot;
                    n_idx       <= last_n ? '0 : n_idx + NW'(1);
                end
                S_NEXT: begin
                    c_acc <= '0;
                    n_idx <= '0;
                    if (last_pair) begin
                        p_idx       <= '0;
                        q_idx       <= PW'(1);
                        sweep       <= sweep + KW'(1);
                        rotated_any <= 1'b0;
                        if (shift != ANGLE_WIDTH'(CORDIC_STAGES - 1)) shift <= shift + ANGLE_WIDTH'(1);
                    end else if (q_idx == PW'(DIM - 1)) begin
                        p_idx <= p_idx + PW'(1);
                        q_idx <= p_idx + PW'(2);
                    end else begin
                        q_idx <= q_idx + PW'(1);
                    end
                end
                S_DONE: begin
                    if (load_wr) begin
                        mem[0] <= bus.serial_z_in;
                        wr_ptr <= AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_simplex_ica_top.sv
// tb/tb_simplex_ica_top.sv - randomized bench for simplex_ica_top against a sweep-level model
module tb_simplex_ica_top;
    localparam int DW = 32;
    localparam int S  = 4;
    localparam int D  = 2;
    localparam int T  = D * S;

    logic          clk;
    logic          rst;
    logic [DW-1:0] z;
    logic          zv, ld, st;
    int            checks = 0;
    int            errors = 0;

    simplex_ica_if #(.DATA_WIDTH(DW), .DIM(D), .SAMPLES(S)) ifa ();
    simplex_ica_if #(.DATA_WIDTH(DW), .DIM(D), .SAMPLES(S)) ifb ();

    assign ifa.serial_z_in    = z;
    assign ifa.serial_z_valid = zv;
    assign ifa.load_data      = ld;
    assign ifa.sica_start     = st;
    assign ifb.serial_z_in    = z;
    assign ifb.serial_z_valid = zv;
    assign ifb.load_data      = ld;
    assign ifb.sica_start     = st;

    simplex_ica_top #(.DATA_WIDTH(DW), .SAMPLES(S), .DIM(D), .MAX_ITERATIONS(8),
        .CORDIC_STAGES(16), .CORDIC_WIDTH(38), .FRAC_WIDTH(20), .LOGM(2), .ANGLE_WIDTH(16))
        dut_a (.clk(clk), .nreset(rst), .bus(ifa.slave));

    simplex_ica_top #(.DATA_WIDTH(DW), .SAMPLES(S), .DIM(D), .MAX_ITERATIONS(1),
        .CORDIC_STAGES(16), .CORDIC_WIDTH(38), .FRAC_WIDTH(20), .LOGM(2), .ANGLE_WIDTH(16))
        dut_b (.clk(clk), .nreset(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint word_a(input int i);
        return longint'($signed(ifa.s_est[i*DW +: DW]));
    endfunction

    function automatic longint word_b(input int i);
        return longint'($signed(ifb.s_est[i*DW +: DW]));
    endfunction

    function automatic longint kinv_of(input int i);
        return longint'($rtoi(1048576.0 / $sqrt(1.0 + 1.0 / (4.0 ** i)) + 0.5));
    endfunction

    function automatic longint fx(input longint x, input longint y);
        return (x * y) >>> 20;
    endfunction

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Whole-algorithm reference: sweeps of pairwise kurtosis-gradient sign rotations
    function automatic void model_run(input longint win[T], input int max_it, output longint res[T]);
        longint x[T];
        x = win;
        for (int k = 0; k < max_it; k++) begin
            bit     rot = 1'b0;
            int     sh  = (k < 15) ? k : 15;
            longint kv  = kinv_of(sh);
            for (int p = 0; p < D - 1; p++) begin
                for (int q = p + 1; q < D; q++) begin
                    longint c = 0;
                    for (int n = 0; n < S; n++) begin
                        longint a = x[p*S+n];
                        longint b = x[q*S+n];
                        c += fx(fx(fx(a, a), a), b) - fx(a, fx(fx(b, b), b));
                    end
                    if (c != 0) begin
                        rot = 1'b1;
                        for (int n = 0; n < S; n++) begin
                            longint a = x[p*S+n];
                            longint b = x[q*S+n];
                            longint sg = (c > 0) ? 1 : -1;
                            x[p*S+n] = sat32(fx(a - sg * (b >>> sh), kv));
                            x[q*S+n] = sat32(fx(b + sg * (a >>> sh), kv));
                        end
                    end
                end
            end
            if (!rot) break;
        end
        res = x;
    endfunction

    task automatic load_window(input longint win[T], input bit gaps, input int extra,
                               output bit first_cc);
        first_cc = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (gaps) begin
                z  = $urandom;
                zv = 1'b0;
                ld = 1'b1;
                @(negedge clk);
            end
            z  = win[i][DW-1:0];
            zv = 1'b1;
            ld = 1'b1;
            @(negedge clk);
            if (i == 0) first_cc = ifa.sica_complete | ifb.sica_complete;
        end
        for (int i = 0; i < extra; i++) begin
            z = $urandom;
            @(negedge clk);
        end
        zv = 1'b0;
        ld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!(ifa.sica_complete && ifb.sica_complete) && n < budget) begin
            st = ($urandom_range(3) == 0);
            @(negedge clk);
            n++;
        end
        st = 1'b0;
        check({tag, "_complete"}, longint'(ifa.sica_complete && ifb.sica_complete), 1);
    endtask

    task automatic check_outputs(input string tag, input longint win[T]);
        longint ea[T];
        longint eb[T];
        model_run(win, 8, ea);
        model_run(win, 1, eb);
        for (int i = 0; i < T; i++) begin
            check($sformatf("%s_a%0d", tag, i), word_a(i), ea[i]);
            check($sformatf("%s_b%0d", tag, i), word_b(i), eb[i]);
        end
    endtask

    task automatic random_window(output longint w[T]);
        for (int i = 0; i < T; i++) w[i] = longint'($urandom_range(2097152)) - 64'sd1048576;
    endtask

    initial begin
        longint win[T];
        bit     fcc;

        z = '0; zv = 1'b0; ld = 1'b0; st = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sest_a", longint'(ifa.s_est != '0), 0);
        check("rst_sest_b", longint'(ifb.s_est != '0), 0);
        check("rst_cc_a", longint'(ifa.sica_complete), 0);
        check("rst_cc_b", longint'(ifb.sica_complete), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_sest_a", longint'(ifa.s_est != '0), 0);
        check("idle_cc_a", longint'(ifa.sica_complete), 0);
        check("idle_cc_b", longint'(ifb.sica_complete), 0);

        win = '{64'sd1048576, 64'sd2097152, 64'sd3145728, 64'sd4194304, 0, 0, 0, 0};
        load_window(win, 1'b0, 0, fcc);
        wait_done("czero", 12);
        for (int i = 0; i < T; i++) check($sformatf("czero_keep%0d", i), word_a(i), win[i]);
        check_outputs("czero", win);

        win = '{64'sd1048576, 0, 0, 0, 64'sd524288, 0, 0, 0};
        load_window(win, 1'b0, 0, fcc);
        check("reload_clears_cc", longint'(fcc), 0);
        wait_done("golden", 400);
        check("golden_x0", word_b(0), 370727);
        check("golden_y0", word_b(4), 1112182);
        check_outputs("golden", win);

        random_window(win);
        load_window(win, 1'b1, 2, fcc);
        wait_done("gaps", 400);
        check_outputs("gaps", win);

        for (int r = 0; r < 6; r++) begin
            random_window(win);
            load_window(win, 1'b0, 0, fcc);
            wait_done($sformatf("rnd%0d", r), 400);
            check_outputs($sformatf("rnd%0d", r), win);
        end

        win = '{64'sd1048576, 0, 0, 0, 64'sd524288, 0, 0, 0};
        load_window(win, 1'b0, 0, fcc);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sest_a", longint'(ifa.s_est != '0), 0);
        check("abort_sest_b", longint'(ifb.s_est != '0), 0);
        check("abort_cc_a", longint'(ifa.sica_complete), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idle_cc_a", longint'(ifa.sica_complete), 0);
        check("abort_idle_cc_b", longint'(ifb.sica_complete), 0);
        random_window(win);
        load_window(win, 1'b0, 0, fcc);
        wait_done("rerun", 400);
        check_outputs("rerun", win);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
